// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I datapath: sequences the shared memory
// port, IR/PC/ALUOut loads, ALU operand muxes and register writeback per instruction.
module multicycle_ctrl #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCLsbClr,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [3:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       retire,
    output logic       trap
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        JALR1    = 4'd11,
        JALR2    = 4'd12,
        LUI      = 4'd13,
        AUIPC    = 4'd14,
        TRAP     = 4'd15
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    state_t state;
    state_t dispatch;

    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt);
        logic [3:0] res;
        case (f3)
            3'b000:  res = alt ? ALU_SUB : ALU_ADD;
            3'b001:  res = ALU_SLL;
            3'b010:  res = ALU_SLT;
            3'b011:  res = ALU_SLTU;
            3'b100:  res = ALU_XOR;
            3'b101:  res = alt ? ALU_SRA : ALU_SRL;
            3'b110:  res = ALU_OR;
            default: res = ALU_AND;
        endcase
        return res;
    endfunction

    // Branches with funct3 010/011 are illegal and are trapped at dispatch.
    always_comb begin
        dispatch = TRAP;
        case (op)
            7'h03, 7'h23: dispatch = MEMADR;
            7'h33:        dispatch = EXECR;
            7'h13:        dispatch = EXECI;
            7'h63:        dispatch = (funct3[2:1] == 2'b01) ? TRAP : BRANCH;
            7'h6F:        dispatch = JAL;
            7'h67:        dispatch = JALR1;
            7'h37:        dispatch = LUI;
            7'h17:        dispatch = AUIPC;
            default:      dispatch = TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= state_t'(RESET_STATE);
        end else begin
            case (state)
                FETCH:    if (mem_ready) state <= DECODE;
                DECODE:   state <= dispatch;
                MEMADR:   state <= (op == 7'h03) ? MEMREAD : MEMWRITE;
                MEMREAD:  if (mem_ready) state <= MEMWB;
                MEMWRITE: if (mem_ready) state <= FETCH;
                EXECR:    state <= ALUWB;
                EXECI:    state <= ALUWB;
                JAL:      state <= ALUWB;
                JALR1:    state <= JALR2;
                JALR2:    state <= ALUWB;
                AUIPC:    state <= ALUWB;
                TRAP:     state <= TRAP;
                default:  state <= FETCH;
            endcase
        end
    end

    // Outputs stay combinational so FETCH/MEMWRITE and BRANCH can react to
    // mem_ready and Zero within the same cycle; everything is forced low in reset.
    always_comb begin
        mem_req    = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        PCLsbClr   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = ALU_ADD;
        ImmSrc     = 3'b000;
        retire     = 1'b0;
        trap       = 1'b0;
        if (rst) begin
            case (op)
                7'h23:        ImmSrc = 3'b001;
                7'h63:        ImmSrc = 3'b010;
                7'h6F:        ImmSrc = 3'b011;
                7'h37, 7'h17: ImmSrc = 3'b100;
                default:      ImmSrc = 3'b000;
            endcase
            case (state)
                FETCH: begin
                    mem_req   = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    IRWrite   = mem_ready;
                    PCWrite   = mem_ready;
                end
                DECODE: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                end
                MEMADR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                end
                MEMREAD: begin
                    mem_req = 1'b1;
                    AdrSrc  = 1'b1;
                end
                MEMWB: begin
                    ResultSrc = 2'b01;
                    RegWrite  = 1'b1;
                    retire    = 1'b1;
                end
                MEMWRITE: begin
                    mem_req  = 1'b1;
                    MemWrite = 1'b1;
                    AdrSrc   = 1'b1;
                    retire   = mem_ready;
                end
                EXECR: begin
                    ALUSrcA    = 2'b10;
                    ALUControl = alu_decode(funct3, funct7b5);
                end
                EXECI: begin
                    ALUSrcA    = 2'b10;
                    ALUSrcB    = 2'b01;
                    ALUControl = alu_decode(funct3, funct7b5 && (funct3 == 3'b101));
                end
                ALUWB: begin
                    RegWrite = 1'b1;
                    retire   = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA = 2'b10;
                    retire  = 1'b1;
                    case (funct3)
                        3'b000: begin ALUControl = ALU_SUB;  PCWrite = Zero;  end
                        3'b001: begin ALUControl = ALU_SUB;  PCWrite = !Zero; end
                        3'b100: begin ALUControl = ALU_SLT;  PCWrite = !Zero; end
                        3'b101: begin ALUControl = ALU_SLT;  PCWrite = Zero;  end
                        3'b110: begin ALUControl = ALU_SLTU; PCWrite = !Zero; end
                        3'b111: begin ALUControl = ALU_SLTU; PCWrite = Zero;  end
                        default: begin ALUControl = ALU_SUB; PCWrite = 1'b0;  end
                    endcase
                end
                JAL: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    PCWrite = 1'b1;
                end
                JALR1: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                end
                JALR2: begin
                    ALUSrcA  = 2'b01;
                    ALUSrcB  = 2'b10;
                    PCWrite  = 1'b1;
                    PCLsbClr = 1'b1;
                end
                LUI: begin
                    ResultSrc = 2'b11;
                    RegWrite  = 1'b1;
                    retire    = 1'b1;
                end
                AUIPC: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                end
                TRAP: begin
                    trap = 1'b1;
                end
                default: begin
                    trap = 1'b0;
                end
            endcase
        end
    end

endmodule
